// File: rtl/md_arbiter_pkg.sv
// Shared definitions for the two-way multiply-divide arbiter: state encoding,
// widths, watchdog limit and the error result value.
package md_arbiter_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned F3_W      = 3;
    localparam int unsigned RD_W      = 5;
    localparam int unsigned OWNER_W   = 1;
    localparam int unsigned STATE_W   = 2;
    localparam int unsigned TMO_CNT_W = 7;
    localparam int unsigned TMO_LIMIT = 100;

    localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] ST_ISSUE = 2'd1;
    localparam logic [STATE_W-1:0] ST_BUSY  = 2'd2;
    localparam logic [STATE_W-1:0] ST_RESP  = 2'd3;

    localparam logic [XLEN-1:0] RESULT_ERR = {XLEN{1'b1}};

    // Payload captured from the granted way and held for the unit
    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [F3_W-1:0] funct3;
        logic [RD_W-1:0] rd_addr;
    } md_req_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: contention resolved by the pointer, a lone
// requester always wins. Purely combinational, one-hot (or zero) grant.
module rr_arbiter2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req_i == 2'b11) begin
            gnt_o = ptr_i ? 2'b10 : 2'b01;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

// File: rtl/md_arbiter.sv
// Arbitrates two ways onto one shared multiply-divide unit and routes the
// result back to the owner. Define MD_ARB_TIMEOUT_EN to add the BUSY watchdog.
module md_arbiter
    import md_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [XLEN-1:0] req0_rs1_i,
    input  logic [XLEN-1:0] req0_rs2_i,
    input  logic [F3_W-1:0] req0_funct3_i,
    input  logic [RD_W-1:0] req0_rdAddr_i,

    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [XLEN-1:0] req1_rs1_i,
    input  logic [XLEN-1:0] req1_rs2_i,
    input  logic [F3_W-1:0] req1_funct3_i,
    input  logic [RD_W-1:0] req1_rdAddr_i,

    output logic            md_valid_o,
    input  logic            md_ready_i,
    output logic [XLEN-1:0] md_rs1_o,
    output logic [XLEN-1:0] md_rs2_o,
    output logic [F3_W-1:0] md_funct3_o,
    input  logic            md_done_i,
    input  logic [XLEN-1:0] md_result_i,

    output logic            rsp0_valid_o,
    input  logic            rsp0_ready_i,
    output logic            rsp1_valid_o,
    input  logic            rsp1_ready_i,
    output logic [XLEN-1:0] rsp_data_o,
`ifdef MD_ARB_TIMEOUT_EN
    output logic            timeout_o,
`endif
    output logic [RD_W-1:0] rsp_rdAddr_o
);

    logic [STATE_W-1:0] state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    md_req_t            req_q, req_d;
    logic [XLEN-1:0]    result_q, result_d;
    logic               run_q;

    logic [1:0]         req_vec;
    logic [1:0]         gnt;
    logic               grant_en;
    logic               owner_ready;

`ifdef MD_ARB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] cnt_q, cnt_d;
    logic                 tmo_q, tmo_d;
`endif

    assign req_vec = {req1_valid_i, req0_valid_i};

    rr_arbiter2 u_rr (
        .req_i (req_vec),
        .ptr_i (ptr_q),
        .gnt_o (gnt)
    );

    // run_q keeps ready low while reset is held and for the release cycle
    assign grant_en     = run_q && (state_q == ST_IDLE);
    assign req0_ready_o = grant_en && gnt[0];
    assign req1_ready_o = grant_en && gnt[1];

    assign owner_ready  = (owner_q == OWNER_W'(0)) ? rsp0_ready_i : rsp1_ready_i;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        req_d    = req_q;
        result_d = result_q;
`ifdef MD_ARB_TIMEOUT_EN
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (grant_en && (gnt != 2'b00)) begin
                    owner_d = OWNER_W'(gnt[1]);
                    ptr_d   = gnt[0];
                    if (gnt[1]) begin
                        req_d = '{rs1: req1_rs1_i, rs2: req1_rs2_i,
                                  funct3: req1_funct3_i, rd_addr: req1_rdAddr_i};
                    end else begin
                        req_d = '{rs1: req0_rs1_i, rs2: req0_rs2_i,
                                  funct3: req0_funct3_i, rd_addr: req0_rdAddr_i};
                    end
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (md_ready_i) begin
                    state_d = ST_BUSY;
`ifdef MD_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (md_done_i) begin
                    result_d = md_result_i;
                    state_d  = ST_RESP;
                end
`ifdef MD_ARB_TIMEOUT_EN
                // cnt_q counts completed BUSY cycles; the 100th without done trips
                else if (cnt_q == TMO_CNT_W'(TMO_LIMIT - 1)) begin
                    tmo_d    = 1'b1;
                    result_d = RESULT_ERR;
                    state_d  = ST_RESP;
                end else begin
                    cnt_d = cnt_q + TMO_CNT_W'(1);
                end
`endif
            end
            ST_RESP: begin
                if (owner_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= '0;
            req_q    <= '0;
            result_q <= '0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            req_q    <= req_d;
            result_q <= result_d;
            run_q    <= 1'b1;
        end
    end

`ifdef MD_ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            tmo_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tmo_q <= tmo_d;
        end
    end

    assign timeout_o = tmo_q;
`endif

    // Outputs decode registered state only, so reset clears them asynchronously
    assign md_valid_o   = (state_q == ST_ISSUE);
    assign md_rs1_o     = req_q.rs1;
    assign md_rs2_o     = req_q.rs2;
    assign md_funct3_o  = req_q.funct3;
    assign rsp0_valid_o = (state_q == ST_RESP) && (owner_q == OWNER_W'(0));
    assign rsp1_valid_o = (state_q == ST_RESP) && (owner_q == OWNER_W'(1));
    assign rsp_data_o   = result_q;
    assign rsp_rdAddr_o = req_q.rd_addr;

endmodule

// File: doc/md_arbiter.md
MD_ARBITER -- requirements
Module: md_arbiter

Interface
REQ-001 The block SHALL have these ports; clock and reset first:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req0_valid_i / req1_valid_i  in  1  way0 / way1 request for the shared multiply-divide unit.
- req0_ready_o / req1_ready_o  out  1  request accepted this cycle.
- reqN_rs1_i, reqN_rs2_i  in  64  operands (N=0,1).
- reqN_funct3_i  in  3  operation select.
- reqN_rdAddr_i  in  5  destination register.
- md_valid_o  out  1  operation issued to the unit.
- md_ready_i  in  1  unit accepts the operation.
- md_rs1_o, md_rs2_o  out  64  latched operands.
- md_funct3_o  out  3  latched operation select.
- md_done_i  in  1  unit result valid, single-cycle pulse.
- md_result_i  in  64  unit result.
- rsp0_valid_o / rsp1_valid_o  out  1  result for the owning way.
- rspN_ready_i  in  1  way consumes result.
- rsp_data_o  out  64  result data, shared by both ways.
- rsp_rdAddr_o  out  5  latched destination register.
- timeout_o  out  1  watchdog error, sticky; present only under MD_ARB_TIMEOUT_EN.

Function
REQ-002 FSM states SHALL be IDLE, ISSUE, BUSY and RESP.
REQ-003 IDLE: if any reqN_valid_i is high, the arbiter SHALL grant one way, assert that way's reqN_ready_o combinationally in the same cycle, latch its operands, funct3, rdAddr and owner id, and go to ISSUE.
REQ-004 Arbitration SHALL be round-robin: a 1-bit priority pointer names the preferred way, and after each grant the pointer points to the non-granted way.
REQ-005 When both ways request and the pointer is 0, way0 SHALL be granted; a single requester SHALL always be granted.
REQ-006 reqN_ready_o SHALL be low in every state except IDLE, and never high for both ways in the same cycle.
REQ-007 ISSUE: md_valid_o SHALL be high with the latched payload held stable; on md_ready_i the FSM SHALL move to BUSY.
REQ-008 BUSY: on md_done_i, md_result_i SHALL be latched and the FSM SHALL move to RESP.
REQ-009 An md_done_i arriving in any state other than BUSY SHALL be ignored.
REQ-010 RESP: rspN_valid_o SHALL be high for the owner only, with rsp_data_o and rsp_rdAddr_o stable; on the owner's rspN_ready_i the FSM SHALL return to IDLE.
REQ-011 Back-to-back latency SHALL be at least 4 cycles per operation: grant, issue, done, response.
REQ-012 The arbiter SHALL NOT grant a new request in the cycle it leaves RESP; that cycle is IDLE re-evaluation on the next edge.
REQ-013 Requests SHALL be held off (not dropped) while not IDLE; requesters keep reqN_valid_i asserted.

Reset
REQ-014 Reset SHALL force the following, with all outputs 0:
- state IDLE;
- priority pointer 0;
- latched payload 0;
- timeout_o 0.
REQ-015 Reset mid-operation SHALL abandon the operation with no response; md_valid_o SHALL drop immediately (asynchronously).

Configuration
REQ-016 With MD_ARB_TIMEOUT_EN defined, the block SHALL have a 7-bit watchdog counter and the timeout_o port, as follows:
- the counter clears on entry to BUSY and increments each BUSY cycle;
- at 100 cycles without md_done_i, the block SHALL set timeout_o sticky until reset, return the owner an all-ones result in RESP, and ignore a later md_done_i.
REQ-017 Without MD_ARB_TIMEOUT_EN, the port and counter SHALL be absent and BUSY waits indefinitely.

Structure
REQ-018 A shared package SHALL hold the FSM state encoding, the owner id width, the timeout limit (100) and the result error value.
REQ-019 The round-robin grant logic SHALL be one sub-module, rr_arbiter2, with inputs req[1:0] and the pointer, and output a one-hot grant.

Verification
REQ-020 A bench SHALL cover these directed scenarios:
- Single way0 request, rs1=6, rs2=7, funct3=0, rdAddr=3, md_ready_i high, done after 5 cycles with result=42 -> rsp0_valid_o=1, rsp_data_o=42, rsp_rdAddr_o=3; rsp1_valid_o stays 0.
- Both ways request continuously from reset -> grants alternate way0, way1, way0, way1 across four operations.
- md_ready_i held low 3 cycles in ISSUE -> md_valid_o stays high, payload unchanged, no grant.
- md_done_i pulse while IDLE -> no response, state unchanged.
- rst_n asserted during BUSY -> all outputs 0 asynchronously; next request granted to way0.
- With MD_ARB_TIMEOUT_EN, no done for 100 cycles -> timeout_o=1, owner receives 0xFFFFFFFFFFFFFFFF; a later done is ignored.
